// File: rtl/polar_to_rect.sv
// polar_to_rect: iterative CORDIC rotator, unsigned amplitude + phase -> signed (real, imag)
// Ports: clk; rst_b (async, active low);
//        in_valid/in_ready/amp/phase  - input handshake, one conversion in flight;
//        out_valid/out_ready/data_real/data_imag - registered, saturated result.
// Define POLAR_TO_RECT_GAIN_COMP_EN to add a COMP state that divides out the CORDIC gain.
module polar_to_rect #(
    parameter int DATA_WIDTH  = 16,
    parameter int PHASE_WIDTH = 16,
    parameter int ITER        = 12
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  amp,
    input  logic [PHASE_WIDTH-1:0] phase,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  data_real,
    output logic [DATA_WIDTH-1:0]  data_imag
);
    localparam int XW = DATA_WIDTH + 2;
    localparam int CW = $clog2(ITER + 1);
    localparam logic signed [XW-1:0] SMAX = XW'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
    localparam logic signed [XW-1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
`ifdef POLAR_TO_RECT_GAIN_COMP_EN
        COMP,
`endif
        DONE
    } state_t;

    // atan(2^-i) in units of 2^-32 cycle, rounded to the configured phase width
    function automatic logic [PHASE_WIDTH-1:0] atan_lut(input int i);
        logic [63:0] t;
        case (i)
            0:  t = 64'h2000_0000;
            1:  t = 64'h12E4_051E;
            2:  t = 64'h09FB_385B;
            3:  t = 64'h0511_11D4;
            4:  t = 64'h028B_0D43;
            5:  t = 64'h0145_D7E1;
            6:  t = 64'h00A2_F61E;
            7:  t = 64'h0051_7C55;
            8:  t = 64'h0028_BE53;
            9:  t = 64'h0014_5F2F;
            10: t = 64'h000A_2F98;
            11: t = 64'h0005_17CC;
            12: t = 64'h0002_8BE6;
            13: t = 64'h0001_45F3;
            14: t = 64'h0000_A2FA;
            15: t = 64'h0000_517D;
            16: t = 64'h0000_28BE;
            17: t = 64'h0000_145F;
            18: t = 64'h0000_0A30;
            19: t = 64'h0000_0518;
            20: t = 64'h0000_028C;
            21: t = 64'h0000_0146;
            22: t = 64'h0000_00A3;
            23: t = 64'h0000_0051;
            24: t = 64'h0000_0029;
            25: t = 64'h0000_0014;
            26: t = 64'h0000_000A;
            27: t = 64'h0000_0005;
            28: t = 64'h0000_0003;
            29: t = 64'h0000_0001;
            30: t = 64'h0000_0001;
            default: t = 64'd0;
        endcase
        return PHASE_WIDTH'((t + (64'd1 << (31 - PHASE_WIDTH))) >> (32 - PHASE_WIDTH));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [XW-1:0] v);
        return v > SMAX ? SMAX[DATA_WIDTH-1:0] : v < SMIN ? SMIN[DATA_WIDTH-1:0] : v[DATA_WIDTH-1:0];
    endfunction

`ifdef POLAR_TO_RECT_GAIN_COMP_EN
    // multiply by ~0.60742 = 1/K with shifts only
    function automatic logic signed [XW-1:0] comp(input logic signed [XW-1:0] v);
        return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
    endfunction
`endif

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic signed [XW-1:0]     x_q, x_d, y_q, y_d, x_r, y_r, a_ld;
    logic signed [PHASE_WIDTH-1:0] z_q, z_d, z_r, at;
    logic [DATA_WIDTH-1:0]    re_q, re_d, im_q, im_d;
    logic [1:0]               quad;
    logic                     neg;

    assign quad = phase[PHASE_WIDTH-1:PHASE_WIDTH-2];
    assign a_ld = amp[DATA_WIDTH-1] ? SMAX : XW'(amp);
    assign neg  = z_q[PHASE_WIDTH-1];
    assign at   = $signed(atan_lut(int'(cnt_q)));
    assign x_r  = neg ? x_q + (y_q >>> cnt_q) : x_q - (y_q >>> cnt_q);
    assign y_r  = neg ? y_q - (x_q >>> cnt_q) : y_q + (x_q >>> cnt_q);
    assign z_r  = neg ? z_q + at : z_q - at;

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign data_real = re_q;
    assign data_imag = im_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        re_d    = re_q;
        im_d    = im_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = ROTATE;
                cnt_d   = '0;
                // quadrant pre-rotation leaves a residual angle in [0, 90) degrees
                x_d     = quad == 2'd0 ? a_ld : quad == 2'd2 ? -a_ld : '0;
                y_d     = quad == 2'd1 ? a_ld : quad == 2'd3 ? -a_ld : '0;
                z_d     = {2'b00, phase[PHASE_WIDTH-3:0]};
            end
            ROTATE: begin
                x_d   = x_r;
                y_d   = y_r;
                z_d   = z_r;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1)) begin
`ifdef POLAR_TO_RECT_GAIN_COMP_EN
                    state_d = COMP;
`else
                    state_d = DONE;
                    re_d    = sat(x_r);
                    im_d    = sat(y_r);
`endif
                end
            end
`ifdef POLAR_TO_RECT_GAIN_COMP_EN
            COMP: begin
                state_d = DONE;
                re_d    = sat(comp(x_q));
                im_d    = sat(comp(y_q));
            end
`endif
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end
endmodule

// File: tb/tb_polar_to_rect.sv
// tb_polar_to_rect: directed vectors for the CORDIC polar-to-rectangular converter
module tb_polar_to_rect;
    localparam int ITER = 12;
`ifdef POLAR_TO_RECT_GAIN_COMP_EN
    localparam int LAT = ITER + 1;
`else
    localparam int LAT = ITER;
`endif

    logic        clk = 1'b0, rst_b = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] amp = '0, phase = '0;
    logic        in_ready, out_valid;
    logic [15:0] data_real, data_imag;
    int          n_chk = 0, n_fail = 0;

    polar_to_rect #(.DATA_WIDTH(16), .PHASE_WIDTH(16), .ITER(ITER)) dut (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
        .amp(amp), .phase(phase), .out_valid(out_valid), .out_ready(out_ready),
        .data_real(data_real), .data_imag(data_imag)
    );

    always #5 clk = ~clk;

    // raw: exact integer CORDIC x/y after ITER micro-rotations, worked by hand
    typedef struct {
        logic [15:0] a;
        logic [15:0] p;
        int          xr;
        int          yr;
    } vec_t;
    vec_t tv[9];

    function automatic int expv(input int raw);
        int v;
`ifdef POLAR_TO_RECT_GAIN_COMP_EN
        v = (raw >>> 1) + (raw >>> 3) - (raw >>> 6) - (raw >>> 9);
`else
        v = raw;
`endif
        return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp, input int tol);
        n_chk++;
        if (act - exp > tol || exp - act > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", nm, act, exp, tol);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input logic [15:0] a, input logic [15:0] p, output int lat);
        chk("in_ready before accept", int'(in_ready), 1, 0);
        amp = a;
        phase = p;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        amp = 16'h1234;
        phase = 16'h5555;
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic ack(input int ex, input int ey);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("out_valid after ack", int'(out_valid), 0, 0);
        chk("in_ready after ack", int'(in_ready), 1, 0);
        chk("real held after ack", int'($signed(data_real)), ex, 2);
        chk("imag held after ack", int'($signed(data_imag)), ey, 2);
    endtask

    initial begin
        int lat;
        tv[0] = '{16'd10000, 16'h0000, 16468, -5};
        tv[1] = '{16'd10000, 16'h4000, 5, 16471};
        tv[2] = '{16'd10000, 16'h8000, -16471, 8};
        tv[3] = '{16'd10000, 16'hC000, -8, -16468};
        tv[4] = '{16'd10000, 16'h2000, 11644, 11646};
        tv[5] = '{16'd10000, 16'h6000, -11646, 11643};
        tv[6] = '{16'hFFFF, 16'h0000, 53959, -13};
        tv[7] = '{16'h8000, 16'h0000, 53959, -13};
        tv[8] = '{16'd0, 16'h1234, 0, 0};

        repeat (3) step();
        chk("reset in_ready", int'(in_ready), 1, 0);
        chk("reset out_valid", int'(out_valid), 0, 0);
        chk("reset data_real", int'(data_real), 0, 0);
        chk("reset data_imag", int'(data_imag), 0, 0);
        rst_b = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            convert(tv[i].a, tv[i].p, lat);
            chk($sformatf("vec%0d latency", i), lat, LAT, 0);
            chk($sformatf("vec%0d real", i), int'($signed(data_real)), expv(tv[i].xr), 2);
            chk($sformatf("vec%0d imag", i), int'($signed(data_imag)), expv(tv[i].yr), 2);
            ack(expv(tv[i].xr), expv(tv[i].yr));
        end

        convert(16'd10000, 16'h2000, lat);
        chk("bp latency", lat, LAT, 0);
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            amp = 16'd5;
            phase = 16'h4000;
            step();
            chk("bp out_valid", int'(out_valid), 1, 0);
            chk("bp in_ready", int'(in_ready), 0, 0);
            chk("bp real stable", int'($signed(data_real)), expv(11644), 2);
            chk("bp imag stable", int'($signed(data_imag)), expv(11646), 2);
        end
        in_valid = 1'b0;
        ack(expv(11644), expv(11646));
        step();
        chk("bp not queued in_ready", int'(in_ready), 1, 0);
        chk("bp not queued out_valid", int'(out_valid), 0, 0);

        amp = 16'd10000;
        phase = 16'h2000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        #2 rst_b = 1'b0;
        #1;
        chk("mid reset out_valid", int'(out_valid), 0, 0);
        chk("mid reset in_ready", int'(in_ready), 1, 0);
        chk("mid reset data_real", int'(data_real), 0, 0);
        chk("mid reset data_imag", int'(data_imag), 0, 0);
        step();
        step();
        rst_b = 1'b1;
        step();
        chk("post reset idle", int'(out_valid), 0, 0);
        convert(tv[0].a, tv[0].p, lat);
        chk("post reset latency", lat, LAT, 0);
        chk("post reset real", int'($signed(data_real)), expv(tv[0].xr), 2);
        chk("post reset imag", int'($signed(data_imag)), expv(tv[0].yr), 2);
        ack(expv(tv[0].xr), expv(tv[0].yr));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
